// File: rtl/sipo_shift_register.sv
// sipo_shift_register: serial-in, parallel-out receiver for the single-wire link.
// Bits arrive LSB first. A completed word is presented in a holding register
// behind a valid/ready handshake. If the holding register is still full, a
// completed word is dropped and overrun pulses for one cycle.
// Optional build macro SIPO_PARITY_EN: each word carries a trailing even-parity
// bit, and a parity_err output loads together with parallel_out.
module sipo_shift_register #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             shift_en,
    input  logic             clear,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] bit_count,
    output logic             overrun
`ifdef SIPO_PARITY_EN
    ,
    output logic             parity_err
`endif
);

`ifdef SIPO_PARITY_EN
    // Data bits are fully shifted in before the parity bit arrives, so the
    // shifter keeps all WIDTH data bits and the parity bit is never stored.
    localparam int SREG_W   = WIDTH;
    localparam int LAST_BIT = WIDTH;
`else
    // The newest bit comes straight from serial_in on the completing edge,
    // so the shifter only needs to hold the WIDTH-1 bits before it.
    localparam int SREG_W   = WIDTH - 1;
    localparam int LAST_BIT = WIDTH - 1;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_BIT);

    logic [SREG_W-1:0] sreg;
    logic [WIDTH-1:0]  word;
    logic              shift_fire;
    logic              complete;
    logic              take;
    logic              load;
    logic              drop;

    // Even parity: error when the data bits plus the parity bit XOR to 1.
    function automatic logic parity_check(input logic [WIDTH-1:0] data, input logic par);
        return (^data) ^ par;
    endfunction

    // Decode shift, completion and handshake events for this edge.
    always_comb begin
        shift_fire = shift_en & ~clear;
        complete   = shift_fire && (bit_count == LAST_CNT);
        take       = out_valid & out_ready;
        load       = complete & (~out_valid | out_ready);
        drop       = complete & ~load;
`ifdef SIPO_PARITY_EN
        word       = sreg;
`else
        word       = {serial_in, sreg};
`endif
    end

    // Shifter and bit counter; clear discards the partial word and wins over shift_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg      <= '0;
            bit_count <= '0;
        end else if (clear) begin
            sreg      <= '0;
            bit_count <= '0;
        end else if (shift_fire) begin
            sreg      <= SREG_W'({serial_in, sreg} >> 1);
            bit_count <= complete ? '0 : bit_count + CNT_W'(1);
        end
    end

    // Holding register and handshake; a load and a transfer can share one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            parallel_out <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err   <= 1'b0;
`endif
        end else begin
            overrun <= drop;
            if (load) begin
                parallel_out <= word;
                out_valid    <= 1'b1;
`ifdef SIPO_PARITY_EN
                parity_err   <= parity_check(sreg, serial_in);
`endif
            end else if (take) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_shift_register.sv
// tb_sipo_shift_register: directed vector table plus hand-written sequences
// for the sipo_shift_register receiver at WIDTH=4.
module tb_sipo_shift_register;

    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             serial_in;
    logic             shift_en;
    logic             clear;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] bit_count;
    logic             overrun;
`ifdef SIPO_PARITY_EN
    logic             parity_err;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             rst;
        logic             sh;
        logic             si;
        logic             clr;
        logic             rdy;
        logic [WIDTH-1:0] po;
        logic             vld;
        logic [CNT_W-1:0] cnt;
        logic             ovr;
    } vec_t;

    vec_t tbl[$];

    sipo_shift_register #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .shift_en     (shift_en),
        .clear        (clear),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .bit_count    (bit_count),
        .overrun      (overrun)
`ifdef SIPO_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic step(input logic r, input logic sh, input logic si, input logic cl, input logic rd);
        rst       = r;
        shift_en  = sh;
        serial_in = si;
        clear     = cl;
        out_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic sh, input logic si, input logic cl, input logic rd,
                       input logic [WIDTH-1:0] po, input logic vld, input logic [CNT_W-1:0] cnt,
                       input logic ovr);
        vec_t v;
        v.rst = r; v.sh = sh; v.si = si; v.clr = cl; v.rdy = rd;
        v.po = po; v.vld = vld; v.cnt = cnt; v.ovr = ovr;
        tbl.push_back(v);
    endtask

    task automatic check_out(input string tag, input logic [WIDTH-1:0] po, input logic vld,
                             input logic [CNT_W-1:0] cnt, input logic ovr);
        chk({tag, " parallel_out"}, 32'(parallel_out), 32'(po));
        chk({tag, " out_valid"},    32'(out_valid),    32'(vld));
        chk({tag, " bit_count"},    32'(bit_count),    32'(cnt));
        chk({tag, " overrun"},      32'(overrun),      32'(ovr));
    endtask

    // Shift a whole data word LSB first; out_ready is raised only on the last edge.
    task automatic send_word(input logic [WIDTH-1:0] w, input logic rdy_last);
        for (int i = 0; i < WIDTH; i++)
            step(1'b0, 1'b1, w[i], 1'b0, (i == WIDTH - 1) ? rdy_last : 1'b0);
    endtask

    initial begin
        rst = 1'b1; shift_en = 1'b0; serial_in = 1'b0; clear = 1'b0; out_ready = 1'b0;

`ifdef SIPO_PARITY_EN
        // Reset while shifting.
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        check_out("par_reset", 4'b0000, 0, 0, 0);
        chk("par_reset parity_err", 32'(parity_err), 32'd0);
        // Data 1011 (three ones) with parity bit 1: even parity holds.
        send_word(4'b1011, 1'b0);
        check_out("par_data_only", 4'b0000, 0, 4, 0);
        step(0, 1, 1, 0, 0);
        check_out("par_good", 4'b1011, 1, 0, 0);
        chk("par_good parity_err", 32'(parity_err), 32'd0);
        step(0, 0, 0, 0, 1);
        chk("par_consume out_valid", 32'(out_valid), 32'd0);
        // Same data with parity bit 0: error flagged, valid only after 5th bit.
        send_word(4'b1011, 1'b0);
        check_out("par_data_only2", 4'b1011, 0, 4, 0);
        step(0, 1, 0, 0, 0);
        check_out("par_bad", 4'b1011, 1, 0, 0);
        chk("par_bad parity_err", 32'(parity_err), 32'd1);
`else
        //   rst sh si clr rdy | po      vld cnt ovr
        // Reset held two edges with shift_en high.
        add(1, 1, 1, 0, 0,  4'b0000, 0, 0, 0);
        add(1, 1, 1, 0, 0,  4'b0000, 0, 0, 0);
        // Basic receive 0,0,1,0 -> 0100, then one-edge consume.
        add(0, 1, 0, 0, 0,  4'b0000, 0, 1, 0);
        add(0, 1, 0, 0, 0,  4'b0000, 0, 2, 0);
        add(0, 1, 1, 0, 0,  4'b0000, 0, 3, 0);
        add(0, 1, 0, 0, 0,  4'b0100, 1, 0, 0);
        add(0, 0, 0, 0, 1,  4'b0100, 0, 0, 0);
        // Gapped receive 1,1,0,1 with three idle cycles between bits -> 1011.
        add(0, 1, 1, 0, 0,  4'b0100, 0, 1, 0);
        add(0, 0, 1, 0, 0,  4'b0100, 0, 1, 0);
        add(0, 0, 0, 0, 0,  4'b0100, 0, 1, 0);
        add(0, 0, 1, 0, 0,  4'b0100, 0, 1, 0);
        add(0, 1, 1, 0, 0,  4'b0100, 0, 2, 0);
        add(0, 0, 0, 0, 0,  4'b0100, 0, 2, 0);
        add(0, 0, 1, 0, 0,  4'b0100, 0, 2, 0);
        add(0, 0, 0, 0, 0,  4'b0100, 0, 2, 0);
        add(0, 1, 0, 0, 0,  4'b0100, 0, 3, 0);
        add(0, 0, 1, 0, 0,  4'b0100, 0, 3, 0);
        add(0, 0, 0, 0, 0,  4'b0100, 0, 3, 0);
        add(0, 0, 1, 0, 0,  4'b0100, 0, 3, 0);
        add(0, 1, 1, 0, 0,  4'b1011, 1, 0, 0);
        // Second word 0110 with holding register full -> dropped, one overrun pulse.
        add(0, 1, 0, 0, 0,  4'b1011, 1, 1, 0);
        add(0, 1, 1, 0, 0,  4'b1011, 1, 2, 0);
        add(0, 1, 1, 0, 0,  4'b1011, 1, 3, 0);
        add(0, 1, 0, 0, 0,  4'b1011, 1, 0, 1);
        add(0, 0, 0, 0, 0,  4'b1011, 1, 0, 0);
        // Same word with out_ready on the completing edge -> replaces, valid stays.
        add(0, 1, 0, 0, 0,  4'b1011, 1, 1, 0);
        add(0, 1, 1, 0, 0,  4'b1011, 1, 2, 0);
        add(0, 1, 1, 0, 0,  4'b1011, 1, 3, 0);
        add(0, 1, 0, 0, 1,  4'b0110, 1, 0, 0);
        add(0, 0, 0, 0, 1,  4'b0110, 0, 0, 0);
        // clear with shift_en after two bits, then 1,0,0,1 -> 1001.
        add(0, 1, 1, 0, 0,  4'b0110, 0, 1, 0);
        add(0, 1, 1, 0, 0,  4'b0110, 0, 2, 0);
        add(0, 1, 1, 1, 0,  4'b0110, 0, 0, 0);
        add(0, 1, 1, 0, 0,  4'b0110, 0, 1, 0);
        add(0, 1, 0, 0, 0,  4'b0110, 0, 2, 0);
        add(0, 1, 0, 0, 0,  4'b0110, 0, 3, 0);
        add(0, 1, 1, 0, 0,  4'b1001, 1, 0, 0);
        // clear does not block a handshake on the same edge.
        add(0, 0, 0, 1, 1,  4'b1001, 0, 0, 0);
        // clear on what would be the completing edge: no load.
        add(0, 1, 1, 0, 1,  4'b1001, 0, 1, 0);
        add(0, 1, 1, 0, 1,  4'b1001, 0, 2, 0);
        add(0, 1, 1, 0, 1,  4'b1001, 0, 3, 0);
        add(0, 1, 1, 1, 1,  4'b1001, 0, 0, 0);
        // Reset mid-word clears everything.
        add(0, 1, 1, 0, 0,  4'b1001, 0, 1, 0);
        add(1, 1, 1, 0, 0,  4'b0000, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].sh, tbl[i].si, tbl[i].clr, tbl[i].rdy);
            check_out($sformatf("row%0d", i), tbl[i].po, tbl[i].vld, tbl[i].cnt, tbl[i].ovr);
        end

        // Drop, then consume, then a fresh word loads cleanly.
        send_word(4'b1010, 1'b0);
        check_out("seq_first", 4'b1010, 1, 0, 0);
        send_word(4'b0101, 1'b0);
        check_out("seq_drop", 4'b1010, 1, 0, 1);
        step(0, 0, 0, 0, 0);
        check_out("seq_pulse_end", 4'b1010, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        check_out("seq_consume", 4'b1010, 0, 0, 0);
        send_word(4'b0011, 1'b0);
        check_out("seq_reload", 4'b0011, 1, 0, 0);
        // Consume and load on the same edge repeatedly.
        send_word(4'b1110, 1'b1);
        check_out("seq_swap1", 4'b1110, 1, 0, 0);
        send_word(4'b0001, 1'b1);
        check_out("seq_swap2", 4'b0001, 1, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
